operand_hazard_ctrl: RTL and testbench

//  Scoreboard and hazard controller for the 4-stage RISC pipeline (IF, ID/DOF, EX, WB).
//  - Tracks pending register writes in EX and WB.
//  - Stalls ID when a source operand is not yet available.
//  - Drives registered forwarding selects to the EX-stage A/B operand paths, ahead of mux A / mux B.
//  - Operand B is checked only when MB=0; a constant operand never hazards.

---
 rtl/operand_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_operand_hazard_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_hazard_ctrl.sv
// Operand hazard controller: scoreboard of pending writes in EX/WB, ID stall, registered EX forwarding selects.
// Latency: stall is combinational from ID fields and scoreboard; fwd_a/fwd_b are registered and apply in the following EX cycle.
// Backpressure: stall freezes PC and IF/ID and injects a bubble into EX; flush overrides stall and squashes the ID instruction.
//
// Optional feature macro: OPERAND_FWD_EN
//   defined   -> EX/WB forwarding, stall only on load-use (1 cycle)
//   undefined -> interlock only, fwd_a/fwd_b tied to 00
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   id_valid              ID stage holds a real instruction
//   id_sa, id_sb          ID source A/B register addresses
//   id_ma, id_mb          1 = operand comes from PC/constant, not the register file
//   id_rw, id_da, id_md   ID writes the register file, destination, is a load
//   flush                 branch taken in EX; squash the ID instruction
//   stall                 freeze PC and IF/ID, bubble into EX
//   fwd_a, fwd_b          EX operand select: 00 regfile, 01 EX result, 10 WB result

module operand_hazard_ctrl #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [AW-1:0] id_sa,
  input  logic [AW-1:0] id_sb,
  input  logic          id_ma,
  input  logic          id_mb,
  input  logic          id_rw,
  input  logic [AW-1:0] id_da,
  input  logic          id_md,
  input  logic          flush,
  output logic          stall,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b
);

  // Scoreboard: the instructions currently in EX and WB
  logic          r_ex_v;
  logic          r_ex_rw;
  logic [AW-1:0] r_ex_da;
  logic          r_wb_v;
  logic          r_wb_rw;
  logic [AW-1:0] r_wb_da;

  logic w_use_a, w_use_b;
  logic w_mex_a, w_mex_b, w_mwb_a, w_mwb_b;
  logic w_haz;
  logic w_issue;

  // Constant operands bypass the register file and so can never hazard
  assign w_use_a = id_valid & ~id_ma;
  assign w_use_b = id_valid & ~id_mb;

  assign w_mex_a = r_ex_v & r_ex_rw & (r_ex_da == id_sa);
  assign w_mex_b = r_ex_v & r_ex_rw & (r_ex_da == id_sb);
  assign w_mwb_a = r_wb_v & r_wb_rw & (r_wb_da == id_sa);
  assign w_mwb_b = r_wb_v & r_wb_rw & (r_wb_da == id_sb);

  // flush wins over any hazard: the ID instruction is discarded anyway
  assign stall   = w_haz & ~flush;
  assign w_issue = id_valid & ~stall & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_v  <= 1'b0;
      r_ex_rw <= 1'b0;
      r_ex_da <= '0;
      r_wb_v  <= 1'b0;
      r_wb_rw <= 1'b0;
      r_wb_da <= '0;
    end else begin
      r_wb_v  <= r_ex_v;
      r_wb_rw <= r_ex_rw;
      r_wb_da <= r_ex_da;
      r_ex_v  <= w_issue;
      r_ex_rw <= id_rw;
      r_ex_da <= id_da;
    end
  end

`ifdef OPERAND_FWD_EN
  logic       r_ex_md;
  logic [1:0] r_fwd_a, r_fwd_b;
  logic [1:0] w_sel_a, w_sel_b;

  // Only a load still in EX cannot be forwarded; everything else is bypassed
  assign w_haz = (w_use_a & w_mex_a & r_ex_md) | (w_use_b & w_mex_b & r_ex_md);

  // EX match checked first so the youngest writer of a register wins
  always_comb begin
    w_sel_a = 2'b00;
    if (w_use_a) begin
      if (w_mex_a & ~r_ex_md) w_sel_a = 2'b01;
      else if (w_mwb_a)       w_sel_a = 2'b10;
    end
    w_sel_b = 2'b00;
    if (w_use_b) begin
      if (w_mex_b & ~r_ex_md) w_sel_b = 2'b01;
      else if (w_mwb_b)       w_sel_b = 2'b10;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_md <= 1'b0;
      r_fwd_a <= 2'b00;
      r_fwd_b <= 2'b00;
    end else begin
      r_ex_md <= id_md;
      // A bubble entering EX must not steer the operand muxes
      r_fwd_a <= w_issue ? w_sel_a : 2'b00;
      r_fwd_b <= w_issue ? w_sel_b : 2'b00;
    end
  end

  assign fwd_a = r_fwd_a;
  assign fwd_b = r_fwd_b;
`else
  logic w_unused_md;

  // No bypass and no regfile write-through: wait until the producer has left WB
  assign w_haz = (w_use_a & (w_mex_a | w_mwb_a)) | (w_use_b & (w_mex_b | w_mwb_b));

  // Load timing is irrelevant when every producer is waited out
  assign w_unused_md = id_md;

  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

endmodule

// File: tb/tb_operand_hazard_ctrl.sv
module tb_operand_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid = 1'b0;
  logic [2:0] id_sa = '0, id_sb = '0, id_da = '0;
  logic       id_ma = 1'b0, id_mb = 1'b0, id_rw = 1'b0, id_md = 1'b0;
  logic       flush = 1'b0;
  logic       stall;
  logic [1:0] fwd_a, fwd_b;

  int checks = 0;
  int errors = 0;
  logic last_stall = 1'b0;

  always #5 clk = ~clk;

  operand_hazard_ctrl #(.AW(3)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_sa(id_sa), .id_sb(id_sb),
    .id_ma(id_ma), .id_mb(id_mb), .id_rw(id_rw), .id_da(id_da), .id_md(id_md),
    .flush(flush), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  // ---------------- behavioural model ----------------
  // In-flight instructions, youngest first: entry 0 is in EX, entry 1 is in WB.
  typedef struct {
    bit       v;
    bit       rw;
    bit [2:0] da;
    bit       md;
  } ins_t;

  ins_t     inflight[$];
  bit [1:0] m_fa = 2'b00, m_fb = 2'b00;

  // Which stage holds the youngest pending writer of register s: 0 none, 1 EX, 2 WB
  function automatic int producer(input bit [2:0] s);
    for (int i = 0; i < inflight.size(); i++)
      if (inflight[i].v && inflight[i].rw && inflight[i].da == s) return i + 1;
    return 0;
  endfunction

  function automatic bit operand_blocked(input bit used, input bit [2:0] s);
    int p;
    if (!used) return 1'b0;
    p = producer(s);
`ifdef OPERAND_FWD_EN
    return (p == 1) && inflight[0].md;
`else
    return p != 0;
`endif
  endfunction

  function automatic bit [1:0] operand_sel(input bit used, input bit [2:0] s);
`ifdef OPERAND_FWD_EN
    int p;
    if (!used) return 2'b00;
    p = producer(s);
    if (p == 1) return 2'b01;
    if (p == 2) return 2'b10;
    return 2'b00;
`else
    return 2'b00;
`endif
  endfunction

  function automatic bit model_stall();
    bit ua, ub;
    ua = id_valid && !id_ma;
    ub = id_valid && !id_mb;
    if (flush) return 1'b0;
    return operand_blocked(ua, id_sa) || operand_blocked(ub, id_sb);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight.delete();
      m_fa = 2'b00;
      m_fb = 2'b00;
    end else begin
      ins_t rec;
      bit   issue;
      issue = id_valid && !flush && !model_stall();
      if (issue) begin
        m_fa = operand_sel(!id_ma, id_sa);
        m_fb = operand_sel(!id_mb, id_sb);
      end else begin
        m_fa = 2'b00;
        m_fb = 2'b00;
      end
      rec.v = issue; rec.rw = id_rw; rec.da = id_da; rec.md = id_md;
      inflight.push_front(rec);
      if (inflight.size() > 2) inflight = inflight[0:1];
    end
  end

  // One compare process, away from the active edge
  always @(negedge clk) begin
    bit es;
    es = model_stall();
    checks++;
    if (stall !== es) begin
      errors++;
      $display("FAIL model_stall t=%0t got=%b want=%b", $time, stall, es);
    end
    checks++;
    if (fwd_a !== m_fa) begin
      errors++;
      $display("FAIL model_fwd_a t=%0t got=%b want=%b", $time, fwd_a, m_fa);
    end
    checks++;
    if (fwd_b !== m_fb) begin
      errors++;
      $display("FAIL model_fwd_b t=%0t got=%b want=%b", $time, fwd_b, m_fb);
    end
    last_stall = stall;
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string name, input logic [1:0] got, input logic [1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  // One clock: drive a new ID instruction just after the edge, then let it settle
  task automatic cyc(input bit v, input bit [2:0] sa, input bit [2:0] sb,
                     input bit ma, input bit mb, input bit rw, input bit [2:0] da,
                     input bit md, input bit fl);
    @(posedge clk);
    #1;
    id_valid = v; id_sa = sa; id_sb = sb; id_ma = ma; id_mb = mb;
    id_rw = rw; id_da = da; id_md = md; flush = fl;
    #1;
  endtask

  task automatic nop();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("reset_stall", {1'b0, stall}, 2'b00);
    chk("reset_fwd_a", fwd_a, 2'b00);
    chk("reset_fwd_b", fwd_b, 2'b00);
    @(posedge clk);
    #1 reset = 1'b0;

    // ADD R3 <- R1,R2 ; SUB R4 <- R3,R5
    cyc(1, 1, 2, 0, 0, 1, 3, 0, 0);
    chk("add_stall", {1'b0, stall}, 2'b00);
    cyc(1, 3, 5, 0, 0, 1, 4, 0, 0);
`ifdef OPERAND_FWD_EN
    chk("sub_nostall", {1'b0, stall}, 2'b00);
    nop();
    chk("sub_fwd_a_ex", fwd_a, 2'b01);
    chk("sub_fwd_b_ex", fwd_b, 2'b00);
`else
    chk("sub_stall1", {1'b0, stall}, 2'b01);
    cyc(1, 3, 5, 0, 0, 1, 4, 0, 0);
    chk("sub_stall2", {1'b0, stall}, 2'b01);
    cyc(1, 3, 5, 0, 0, 1, 4, 0, 0);
    chk("sub_released", {1'b0, stall}, 2'b00);
    nop();
    chk("sub_fwd_a_ex", fwd_a, 2'b00);
`endif
    nop(); nop();

    // LD R2 ; ADD R6 <- R1,R2
    cyc(1, 7, 0, 0, 1, 1, 2, 1, 0);
    cyc(1, 1, 2, 0, 0, 1, 6, 0, 0);
    chk("ldu_stall1", {1'b0, stall}, 2'b01);
`ifdef OPERAND_FWD_EN
    cyc(1, 1, 2, 0, 0, 1, 6, 0, 0);
    chk("ldu_released", {1'b0, stall}, 2'b00);
    nop();
    chk("ldu_fwd_b", fwd_b, 2'b10);
    chk("ldu_fwd_a", fwd_a, 2'b00);
`else
    cyc(1, 1, 2, 0, 0, 1, 6, 0, 0);
    chk("ldu_stall2", {1'b0, stall}, 2'b01);
    cyc(1, 1, 2, 0, 0, 1, 6, 0, 0);
    chk("ldu_released", {1'b0, stall}, 2'b00);
    nop();
    chk("ldu_fwd_b", fwd_b, 2'b00);
`endif
    nop(); nop();

    // ADD R2 <- R1,R1 ; ADI R6 <- R1,#5 with id_sb = R2
    cyc(1, 1, 1, 0, 0, 1, 2, 0, 0);
    cyc(1, 1, 2, 0, 1, 1, 6, 0, 0);
    chk("const_nostall", {1'b0, stall}, 2'b00);
    nop();
    chk("const_fwd_b", fwd_b, 2'b00);
    nop(); nop();

    // ADD R3 ; ADD R3 ; OR R7 <- R3,R3
    cyc(1, 1, 1, 0, 0, 1, 3, 0, 0);
    cyc(1, 1, 1, 0, 0, 1, 3, 0, 0);
    cyc(1, 3, 3, 0, 0, 1, 7, 0, 0);
`ifdef OPERAND_FWD_EN
    chk("youngest_nostall", {1'b0, stall}, 2'b00);
    nop();
    chk("youngest_fwd_a", fwd_a, 2'b01);
    chk("youngest_fwd_b", fwd_b, 2'b01);
`else
    chk("youngest_stall", {1'b0, stall}, 2'b01);
    cyc(1, 3, 3, 0, 0, 1, 7, 0, 0);
    cyc(1, 3, 3, 0, 0, 1, 7, 0, 0);
    chk("youngest_released", {1'b0, stall}, 2'b00);
    nop();
`endif
    nop(); nop();

    // Flush with a hazard pending: ADD R3 ; SUB R4 <- R3,R5 flushed ; AND R5 <- R4,R4
    cyc(1, 1, 1, 0, 0, 1, 3, 0, 0);
    cyc(1, 3, 5, 0, 0, 1, 4, 1, 1);
    chk("flush_stall", {1'b0, stall}, 2'b00);
    cyc(1, 4, 4, 0, 0, 1, 5, 0, 0);
    chk("flush_bubble_fwd_a", fwd_a, 2'b00);
    chk("flush_bubble_fwd_b", fwd_b, 2'b00);
    chk("flush_no_r4_write", {1'b0, stall}, 2'b00);
    nop(); nop();

    // Reset in the middle of a load-use stall
    cyc(1, 7, 0, 0, 1, 1, 3, 1, 0);
    cyc(1, 3, 5, 0, 0, 1, 4, 0, 0);
    chk("pre_reset_stall", {1'b0, stall}, 2'b01);
    #1 reset = 1'b1;
    #1;
    chk("mid_reset_stall", {1'b0, stall}, 2'b00);
    chk("mid_reset_fwd_a", fwd_a, 2'b00);
    chk("mid_reset_fwd_b", fwd_b, 2'b00);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("post_reset_empty", {1'b0, stall}, 2'b00);

    // Randomized traffic; IF/ID holds its instruction while stalled
    for (int n = 0; n < 800; n++) begin
      @(posedge clk);
      #1;
      if (!(last_stall && !flush)) begin
        id_valid = ($urandom_range(0, 99) < 85);
        id_sa    = 3'($urandom_range(0, 3));
        id_sb    = 3'($urandom_range(0, 3));
        id_ma    = ($urandom_range(0, 99) < 20);
        id_mb    = ($urandom_range(0, 99) < 25);
        id_rw    = ($urandom_range(0, 99) < 75);
        id_da    = 3'($urandom_range(0, 3));
        id_md    = ($urandom_range(0, 99) < 30);
      end
      flush = ($urandom_range(0, 99) < 8);
      if (n == 400) begin
        #1 reset = 1'b1;
        #2 reset = 1'b0;
      end
    end

    @(posedge clk);
    #1;
    id_valid = 1'b0;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
